// File: rtl/if_stage_pkg.sv
// ----------------------------------------------------------------------------
// if_stage_pkg
// Shared constants and types for the fetch (IF) stage and its neighbours.
//   NOP_INST         : word substituted for faulting or cancelled fetches
//                      (LoongArch andi r0,r0,0)
//   RESET_PC         : reset value of fs_pc (debug visibility only)
//   fs_to_ds_bus_t   : IF -> ID payload {excp, pc, inst}
//   FS_TO_DS_BUS_WD  : payload width, identical with or without IF_ADEF_EN
// ----------------------------------------------------------------------------
package if_stage_pkg;

    localparam logic [31:0] NOP_INST = 32'h0340_0000;
    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    // The excp bit is always present so the bus width never depends on the build.
    typedef struct packed {
        logic        excp;
        logic [31:0] pc;
        logic [31:0] inst;
    } fs_to_ds_bus_t;

    localparam int unsigned FS_TO_DS_BUS_WD = 1 + 32 + 32;

    // Instruction fetch address error: PC not word aligned.
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_inst_buf.sv
// ----------------------------------------------------------------------------
// if_inst_buf
// One-entry skid buffer for the instruction SRAM read data. The SRAM returns
// data one cycle after the request and the address keeps moving, so the word
// for the PC held in IF must be captured in the only cycle it is on the bus.
//
// Ports:
//   clk       in   clock
//   reset     in   synchronous, active-high reset
//   clear     in   drop the buffered word (new load or branch cancel)
//   capture   in   store rdata; asserted only in the cycle rdata matches fs_pc
//   fresh     in   rdata belongs to the PC currently held in IF
//   rdata     in   instruction SRAM read data
//   buf_valid out  buffer holds the word for the current PC
//   inst      out  buffered word, else live rdata when fresh, else NOP_INST
// ----------------------------------------------------------------------------
module if_inst_buf
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        capture,
    input  logic        fresh,
    input  logic [31:0] rdata,
    output logic        buf_valid,
    output logic [31:0] inst
);

    logic        buf_valid_q;
    logic [31:0] inst_buf_q;

    // clear and capture are mutually exclusive by construction in the parent;
    // clear still wins so a cancel can never leave a stale word behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            inst_buf_q  <= '0;
        end else if (clear) begin
            buf_valid_q <= 1'b0;
        end else if (capture) begin
            buf_valid_q <= 1'b1;
            inst_buf_q  <= rdata;
        end
    end

    assign buf_valid = buf_valid_q;

    always_comb begin
        inst = NOP_INST;
        if (buf_valid_q) begin
            inst = inst_buf_q;
        end else if (fresh) begin
            inst = rdata;
        end
    end

endmodule

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
// Fetch stage sitting directly after the pre-IF PC generator. Latches the PC
// issued by pre-IF, pairs it with the instruction SRAM data that returns one
// cycle later, holds that word across decode back-pressure and squashes its
// contents on a taken-branch cancel.
//
// Optional build macro: IF_ADEF_EN
//   defined   : misaligned PCs raise fs_excp; their instruction reads as NOP
//   undefined : fs_excp tied 0, misaligned PCs fetched as normal
//
// Ports:
//   clk              in   clock
//   reset            in   synchronous, active-high reset
//   ps_to_fs_valid   in   pre-IF offers a PC this cycle
//   ps_pc[31:0]      in   PC whose SRAM request is issued this cycle
//   fs_allowin       out  IF can accept ps_pc this cycle
//   inst_sram_rdata  in   SRAM data for the request issued last cycle
//   br_taken_cancel  in   branch resolved taken; squash IF contents
//   ds_allowin       in   decode accepts IF outputs this cycle
//   fs_to_ds_valid   out  fs_pc/fs_inst valid for decode
//   fs_pc[31:0]      out  PC of the instruction held in IF
//   fs_inst[31:0]    out  instruction held in IF
//   fs_excp          out  fetch exception flag
// ----------------------------------------------------------------------------
module if_stage
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ps_to_fs_valid,
    input  logic [31:0] ps_pc,
    output logic        fs_allowin,
    input  logic [31:0] inst_sram_rdata,
    input  logic        br_taken_cancel,
    input  logic        ds_allowin,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic        fs_excp
);

    logic        fs_valid_q, fs_valid_d;
    logic        fresh_q, fresh_d;
    logic [31:0] fs_pc_q, fs_pc_d;

    logic        buf_valid;
    logic [31:0] buf_inst;
    logic        excp;

    logic        fs_ready_go;
    logic        allowin;
    logic        capture;
    logic        clear;

    fs_to_ds_bus_t                bus;
    logic [FS_TO_DS_BUS_WD-1:0]   bus_flat;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    // The word for fs_pc is available either live on the SRAM bus (first
    // cycle only) or from the skid buffer afterwards.
    assign fs_ready_go = fresh_q | buf_valid;
    assign allowin     = !fs_valid_q | (fs_ready_go & ds_allowin);
    assign fs_allowin  = allowin;

    // Capture on the single cycle rdata matches fs_pc and decode is stalled.
    // allowin is necessarily 0 here, so capture never collides with a load.
    assign capture = fs_valid_q & fresh_q & !ds_allowin & !buf_valid & !br_taken_cancel;
    assign clear   = br_taken_cancel | allowin;

    // ------------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------------
    always_comb begin
        fs_valid_d = fs_valid_q;
        fresh_d    = 1'b0;
        fs_pc_d    = fs_pc_q;
        if (br_taken_cancel) begin
            // The PC offered in this cycle is dropped; pre-IF redirects itself.
            fs_valid_d = 1'b0;
            fresh_d    = 1'b0;
        end else if (allowin) begin
            fs_valid_d = ps_to_fs_valid;
            fresh_d    = ps_to_fs_valid;
            fs_pc_d    = ps_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid_q <= 1'b0;
            fresh_q    <= 1'b0;
            fs_pc_q    <= RESET_PC;
        end else begin
            fs_valid_q <= fs_valid_d;
            fresh_q    <= fresh_d;
            fs_pc_q    <= fs_pc_d;
        end
    end

    // ------------------------------------------------------------------------
    // Skid buffer
    // ------------------------------------------------------------------------
    if_inst_buf u_inst_buf (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .capture   (capture),
        .fresh     (fresh_q),
        .rdata     (inst_sram_rdata),
        .buf_valid (buf_valid),
        .inst      (buf_inst)
    );

    // ------------------------------------------------------------------------
    // Fetch address exception
    // ------------------------------------------------------------------------
`ifdef IF_ADEF_EN
    logic fs_excp_q, fs_excp_d;

    always_comb begin
        fs_excp_d = fs_excp_q;
        if (br_taken_cancel) begin
            fs_excp_d = 1'b0;
        end else if (allowin) begin
            fs_excp_d = pc_misaligned(ps_pc);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fs_excp_q <= 1'b0;
        end else begin
            fs_excp_q <= fs_excp_d;
        end
    end

    assign excp = fs_excp_q;
`else
    assign excp = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Outputs to decode
    // ------------------------------------------------------------------------
    // Reset forces the payload to a benign NOP even before the registers settle.
    assign bus.excp = !reset & excp;
    assign bus.pc   = fs_pc_q;
    assign bus.inst = (reset | excp) ? NOP_INST : buf_inst;
    assign bus_flat = bus;

    assign {fs_excp, fs_pc, fs_inst} = bus_flat;

    assign fs_to_ds_valid = !reset & fs_valid_q & fs_ready_go & !br_taken_cancel;

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage. A behavioural model tracks the single
// instruction held in IF as {valid, pc, excp}; the expected instruction word
// is whatever the SRAM returned for that pc, independent of what is currently
// on the SRAM bus. Directed scenarios are followed by randomized traffic.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_if_stage;

    localparam logic [31:0] NOP      = 32'h0340_0000;
    localparam logic [31:0] RST_PC   = 32'h1c00_0000;
    localparam logic [31:0] SRAM_KEY = 32'hA5A5_A5A5;
`ifdef IF_ADEF_EN
    localparam bit ADEF = 1'b1;
`else
    localparam bit ADEF = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        ps_to_fs_valid;
    logic [31:0] ps_pc;
    logic        fs_allowin;
    logic [31:0] inst_sram_rdata;
    logic        br_taken_cancel;
    logic        ds_allowin;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        fs_excp;

    if_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ps_to_fs_valid  (ps_to_fs_valid),
        .ps_pc           (ps_pc),
        .fs_allowin      (fs_allowin),
        .inst_sram_rdata (inst_sram_rdata),
        .br_taken_cancel (br_taken_cancel),
        .ds_allowin      (ds_allowin),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_pc           (fs_pc),
        .fs_inst         (fs_inst),
        .fs_excp         (fs_excp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: the instruction currently owned by IF.
    bit          m_valid;
    bit          m_pc_known;
    bit          m_excp;
    logic [31:0] m_pc;
    logic [31:0] prev_pc;
    int          handoffs_08;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs, check outputs mid-cycle, advance the model.
    task automatic step(input logic rst, input logic pv, input logic [31:0] pc,
                        input logic cn, input logic dsa, input logic [31:0] rdata);
        logic [31:0] exp_inst;
        reset           = rst;
        ps_to_fs_valid  = pv;
        ps_pc           = pc;
        br_taken_cancel = cn;
        ds_allowin      = dsa;
        inst_sram_rdata = rdata;
        @(negedge clk);

        exp_inst = (m_valid && !m_excp && !rst) ? (m_pc ^ SRAM_KEY) : NOP;
        check_val("to_ds_valid", {31'd0, fs_to_ds_valid}, {31'd0, m_valid && !cn && !rst});
        check_val("allowin", {31'd0, fs_allowin}, {31'd0, !m_valid || dsa});
        check_val("inst", fs_inst, exp_inst);
        check_val("excp", {31'd0, fs_excp}, {31'd0, m_excp && !rst});
        if (m_pc_known) check_val("pc", fs_pc, m_pc);

        if (!rst && fs_to_ds_valid && dsa && fs_pc == 32'h1c00_0008) handoffs_08++;

        if (rst) begin
            m_valid    = 1'b0;
            m_pc       = RST_PC;
            m_pc_known = 1'b1;
            m_excp     = 1'b0;
        end else if (cn) begin
            m_valid    = 1'b0;
            m_pc_known = 1'b0;
            m_excp     = 1'b0;
        end else if (!m_valid || dsa) begin
            m_valid    = pv;
            m_pc       = pc;
            m_pc_known = 1'b1;
            m_excp     = ADEF && (pc[1:0] != 2'b00);
        end
        prev_pc = pc;
        @(posedge clk);
        #1;
    endtask

    // Normal cycle: SRAM answers for last cycle's address.
    task automatic cyc(input logic pv, input logic [31:0] pc, input logic cn, input logic dsa);
        step(1'b0, pv, pc, cn, dsa, prev_pc ^ SRAM_KEY);
    endtask

    initial begin
        logic        r_pv, r_cn, r_dsa, r_rst;
        logic [31:0] r_pc;

        reset           = 1'b1;
        ps_to_fs_valid  = 1'b0;
        ps_pc           = '0;
        br_taken_cancel = 1'b0;
        ds_allowin      = 1'b0;
        inst_sram_rdata = '0;
        prev_pc         = '0;
        handoffs_08     = 0;
        @(posedge clk);
        #1;
        m_valid    = 1'b0;
        m_pc       = RST_PC;
        m_pc_known = 1'b1;
        m_excp     = 1'b0;

        // Held under reset
        step(1'b1, 1'b1, 32'h1c00_0000, 1'b0, 1'b1, 32'h1234_5678);

        // Free-run, no back-pressure
        for (int i = 0; i < 3; i++) cyc(1'b1, RST_PC + 32'(4 * i), 1'b0, 1'b1);

        // Decode stalls 3 cycles on pc 0x1c000008; bus garbage after first cycle
        step(1'b0, 1'b1, 32'h1c00_000c, 1'b0, 1'b0, prev_pc ^ SRAM_KEY);
        step(1'b0, 1'b1, 32'h1c00_0010, 1'b0, 1'b0, 32'hDEAD_BEEF);
        step(1'b0, 1'b1, 32'h1c00_0010, 1'b0, 1'b0, 32'hDEAD_BEEF);
        cyc(1'b1, 32'h1c00_000c, 1'b0, 1'b1);
        cyc(1'b1, 32'h1c00_0010, 1'b0, 1'b1);
        cyc(1'b1, 32'h1c00_0014, 1'b0, 1'b1);
        check_val("handoff_once", 32'(handoffs_08), 32'd1);

        // Cancel while buffered
        cyc(1'b1, 32'h1c00_0018, 1'b0, 1'b0);
        cyc(1'b1, 32'h1c00_0018, 1'b1, 1'b0);
        cyc(1'b1, 32'h1c00_0100, 1'b0, 1'b1);
        cyc(1'b1, 32'h1c00_0104, 1'b0, 1'b1);

        // Cancel coincident with an accepted offer
        cyc(1'b1, 32'h1c00_0108, 1'b1, 1'b1);
        cyc(1'b0, 32'h1c00_010c, 1'b0, 1'b1);

        // Reset in the middle of a buffered stall
        cyc(1'b1, 32'h1c00_0200, 1'b0, 1'b1);
        cyc(1'b1, 32'h1c00_0204, 1'b0, 1'b0);
        cyc(1'b1, 32'h1c00_0204, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h1c00_0204, 1'b0, 1'b0, prev_pc ^ SRAM_KEY);
        cyc(1'b0, 32'h1c00_0204, 1'b0, 1'b1);

        // Misaligned fetch followed by an aligned one
        cyc(1'b1, 32'h1c00_0002, 1'b0, 1'b1);
        cyc(1'b1, 32'h1c00_0004, 1'b0, 1'b1);
        cyc(1'b0, 32'h1c00_0008, 1'b0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r_pv  = ($urandom_range(0, 3) != 0);
            r_cn  = ($urandom_range(0, 9) == 0);
            r_dsa = ($urandom_range(0, 3) != 0);
            r_rst = ($urandom_range(0, 99) == 0);
            r_pc  = $urandom;
            if ($urandom_range(0, 7) != 0) r_pc[1:0] = 2'b00;
            step(r_rst, r_pv, r_pc, r_cn, r_dsa, prev_pc ^ SRAM_KEY);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
